// File: rtl/aud_smpl_queue_pkg.sv
// Shared types and default geometry for the FIR sample queue.
package aud_q_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned NUM_TAPS = 1021;
  localparam int unsigned PTR_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SEQ   = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] lft;
    logic signed [DATA_W-1:0] rght;
  } smpl_pair_t;

endpackage

// File: rtl/aud_smpl_queue_if.sv
// Sample write strobe and replay-burst outputs between the audio front end and the FIR.
interface aud_smpl_queue_if #(
  parameter int unsigned DATA_W = aud_q_pkg::DATA_W
);

  logic                     wrt_smpl;
  logic signed [DATA_W-1:0] lft_smpl;
  logic signed [DATA_W-1:0] rght_smpl;
  logic                     sequencing;
  logic signed [DATA_W-1:0] lft_out;
  logic signed [DATA_W-1:0] rght_out;
  logic                     full;

  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
    input  sequencing, lft_out, rght_out, full
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rght_smpl,
    output sequencing, lft_out, rght_out, full
  );

endinterface

// File: rtl/aud_smpl_queue_dpram.sv
// Simple dual-port sample RAM: synchronous write, registered read (1-cycle latency), no array reset.
module aud_dpram #(
  parameter int unsigned WIDTH = 2 * aud_q_pkg::DATA_W,
  parameter int unsigned DEPTH = aud_q_pkg::DEPTH,
  parameter int unsigned AW    = aud_q_pkg::PTR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/aud_smpl_queue.sv
// Circular stereo sample queue that replays the newest NUM_TAPS pairs, oldest first, to the FIR.
module aud_smpl_queue #(
  parameter int unsigned DATA_W   = aud_q_pkg::DATA_W,
  parameter int unsigned DEPTH    = aud_q_pkg::DEPTH,
  parameter int unsigned NUM_TAPS = aud_q_pkg::NUM_TAPS,
  parameter int unsigned PTR_W    = aud_q_pkg::PTR_W
) (
  input  logic            clk,
  input  logic            rst,
  aud_smpl_queue_if.slave bus
);

  import aud_q_pkg::*;

  localparam logic [PTR_W-1:0] TAPS_P = PTR_W'(NUM_TAPS);
  localparam logic [PTR_W-1:0] LAST_K = PTR_W'(NUM_TAPS - 1);
  localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      new_ptr;
  logic [PTR_W-1:0]      cnt;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_addr;
  logic [PTR_W-1:0]      tap_k;
  logic                  pend;
  logic                  req;
  logic                  last_tap;
  logic                  rd_en;
  logic [2*DATA_W-1:0]   ram_q;

  // cnt saturates at NUM_TAPS, so a write requests a burst when it fills or finds the queue full
  assign req      = bus.wrt_smpl && (cnt >= LAST_K);
  assign last_tap = (state == SEQ) && (tap_k == LAST_K);
  assign rd_en    = (state != IDLE);
  assign bus.full = (cnt == TAPS_P);

  // Window start is taken from new_ptr during PRIME so a follow-up burst sees every queued write
  always_comb begin
    rd_addr = rd_ptr;
    if (state == PRIME) rd_addr = new_ptr - TAPS_P;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = PRIME;
      PRIME:   state_nxt = SEQ;
      SEQ:     if (last_tap) state_nxt = (pend || req) ? PRIME : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  aud_dpram #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (bus.wrt_smpl),
    .waddr (new_ptr),
    .wdata ({bus.lft_smpl, bus.rght_smpl}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_ptr <= '0;
      cnt     <= '0;
      state   <= IDLE;
      pend    <= 1'b0;
      rd_ptr  <= '0;
      tap_k   <= '0;
    end else begin
      if (bus.wrt_smpl) begin
        new_ptr <= new_ptr + ONE_P;
        if (cnt != TAPS_P) cnt <= cnt + ONE_P;
      end
      state <= state_nxt;
      // Writes landing mid-burst collapse into a single follow-up request
      if (state == IDLE || last_tap) pend <= 1'b0;
      else if (req)                   pend <= 1'b1;
      if (rd_en) rd_ptr <= rd_addr + ONE_P;
      if (state == SEQ) tap_k <= tap_k + ONE_P;
      else              tap_k <= '0;
    end
  end

  // RAM data for tap k arrives during the k-th SEQ cycle and is registered onto the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sequencing <= 1'b0;
      bus.lft_out    <= '0;
      bus.rght_out   <= '0;
    end else begin
      bus.sequencing <= (state == SEQ);
      if (state == SEQ) begin
        bus.lft_out  <= ram_q[2*DATA_W-1:DATA_W];
        bus.rght_out <= ram_q[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_aud_smpl_queue.sv
// Randomised scoreboard bench for aud_smpl_queue against a window-replay reference model.
module tb_aud_smpl_queue;

  import aud_q_pkg::*;

  localparam int unsigned N  = NUM_TAPS;
  localparam int unsigned DW = DATA_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  aud_smpl_queue_if #(.DATA_W(DW)) bus ();

  aud_smpl_queue #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_TAPS (NUM_TAPS),
    .PTR_W    (PTR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle", name, act, exp);
    end
  endtask

  // Reference model: bursts replay the newest N samples written up to their start edge.
  // A burst starting at edge p is busy through edge p+N+1; writes in that span queue one follow-up at p+N+1.
  smpl_pair_t  hist[$];
  smpl_pair_t  expq[$];
  int unsigned startq[$];
  int unsigned cyc      = 0;
  int unsigned m_cnt    = 0;
  int unsigned p_cur    = 0;
  bit          m_active = 1'b0;
  bit          m_pend   = 1'b0;
  bit          m_wrfull = 1'b0;

  function automatic void m_start(input int unsigned c);
    for (int k = 0; k < int'(N); k++) expq.push_back(hist[hist.size() - N + k]);
    startq.push_back(c + 2);
    m_active = 1'b1;
    p_cur    = c;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist.delete();
      expq.delete();
      startq.delete();
      m_cnt    = 0;
      m_active = 1'b0;
      m_pend   = 1'b0;
    end else begin
      m_wrfull = 1'b0;
      if (bus.wrt_smpl) begin
        hist.push_back('{bus.lft_smpl, bus.rght_smpl});
        if (hist.size() > N) void'(hist.pop_front());
        if (m_cnt < N) m_cnt++;
        m_wrfull = (m_cnt == N);
      end
      if (m_active && cyc == p_cur + N + 1) begin
        m_active = 1'b0;
        if (m_pend || m_wrfull) begin
          m_pend = 1'b0;
          m_start(cyc);
        end
      end else if (m_wrfull) begin
        if (m_active) m_pend = 1'b1;
        else          m_start(cyc);
      end
    end
  end

  int unsigned run_len = 0;
  logic signed [DW-1:0] hold_l = '0;
  logic signed [DW-1:0] hold_r = '0;

  always @(negedge clk) begin
    smpl_pair_t e;
    if (rst) begin
      run_len = 0;
      hold_l  = '0;
      hold_r  = '0;
    end else begin
      check("full", bus.full, (m_cnt == N));
      if (bus.sequencing) begin
        if (run_len == 0) begin
          if (startq.size() == 0) check("seq_rise_unexpected", bus.sequencing, 0);
          else                    check("seq_rise_cycle", cyc, startq.pop_front());
        end
        run_len++;
        if (expq.size() == 0) begin
          check("seq_spurious", bus.sequencing, 0);
        end else begin
          e = expq.pop_front();
          check("lft_out", bus.lft_out, e.lft);
          check("rght_out", bus.rght_out, e.rght);
        end
        hold_l = bus.lft_out;
        hold_r = bus.rght_out;
      end else begin
        if (run_len != 0) check("burst_len", run_len, N);
        run_len = 0;
        check("lft_hold", bus.lft_out, hold_l);
        check("rght_hold", bus.rght_out, hold_r);
      end
    end
  end

  // Driver is always parked at a negedge; a write issued here is sampled at edge cyc+1.
  task automatic wr(input logic signed [DW-1:0] l, input logic signed [DW-1:0] r);
    bus.wrt_smpl  = 1'b1;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    @(negedge clk);
    bus.wrt_smpl  = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!m_active && expq.size() == 0 && !bus.sequencing && run_len == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout actual=%0d pending samples required=0", expq.size());
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_seq"},  bus.sequencing, 0);
    check({tag, "_lft"},  bus.lft_out, 0);
    check({tag, "_rght"}, bus.rght_out, 0);
    check({tag, "_full"}, bus.full, 0);
    gap(3);
    rst = 1'b0;
  endtask

  int unsigned i;
  int unsigned p;
  logic signed [DW-1:0] sv;

  initial begin
    rst           = 1'b1;
    bus.wrt_smpl  = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    @(negedge clk);
    reset_check("rst_init");

    // Partial fill then reset: these samples must not count toward the next burst
    for (int k = 0; k < 400; k++) begin
      wr(DW'(k + 7000), DW'(-(k + 7000)));
      gap($urandom_range(0, 2));
    end
    reset_check("rst_mid_stream");

    // N-1 writes: no burst, not full
    for (i = 0; i < N - 1; i++) begin
      sv = DW'(i);
      wr(sv, -sv);
      gap($urandom_range(0, 2));
    end
    check("full_before_fill", bus.full, 0);

    sv = DW'(i);
    wr(sv, -sv);
    i++;
    check("full_after_fill", bus.full, 1);
    wait_idle();

    sv = DW'(i);
    wr(sv, -sv);
    i++;
    wait_idle();

    // Back-to-back bursts; the window crosses the 1023->0 wrap once ~1025 samples are in
    for (int b = 0; b < 14; b++) begin
      sv = (b >= 7) ? DW'($urandom) : DW'(i);
      wr(sv, (b >= 7) ? DW'($urandom) : -sv);
      i++;
      p = cyc;
      if (b % 3 == 1) begin
        gap((b == 1) ? 0 : $urandom_range(1, 400));
        sv = DW'(i);
        wr(sv, -sv);
        i++;
        gap($urandom_range(0, 400));
        sv = DW'($urandom);
        wr(sv, DW'($urandom));
        i++;
      end else if (b % 3 == 2) begin
        gap($urandom_range(0, 400));
        sv = DW'(i);
        wr(sv, -sv);
        i++;
        while (cyc < p + N) @(negedge clk);
        sv = DW'(i);
        wr(sv, -sv);
        i++;
      end
      wait_idle();
      gap($urandom_range(0, 3));
    end

    // Reset mid-burst ends it at once; later writes must start a fresh fill
    wr(DW'(i), -DW'(i));
    gap(100);
    reset_check("rst_mid_burst");
    for (int k = 0; k < 50; k++) begin
      wr(DW'($urandom), DW'($urandom));
      gap($urandom_range(0, 2));
    end
    gap(20);
    check("leftover_expected", expq.size(), 0);
    check("full_after_refill", bus.full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
